// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline: ALU control codes, the
// condition-code register layout, and the rule for which codes touch flags.
package pipe_pkg;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] SETC = 4'd1;
    localparam logic [3:0] CLRC = 4'd2;
    localparam logic [3:0] NOTR = 4'd3;
    localparam logic [3:0] MOV  = 4'd4;
    localparam logic [3:0] ADD  = 4'd5;
    localparam logic [3:0] SUB  = 4'd6;
    localparam logic [3:0] ANDR = 4'd7;
    localparam logic [3:0] ORR  = 4'd8;
    localparam logic [3:0] INC  = 4'd9;
    localparam logic [3:0] DEC  = 4'd10;
    localparam logic [3:0] SHL  = 4'd11;
    localparam logic [3:0] SHR  = 4'd12;
    localparam logic [3:0] STD  = 4'd13;
    localparam logic [3:0] LDM  = 4'd14;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
    } ccr_t;

    // Codes 1..12 except MOV produce flags; NOP, MOV, STD, LDM and 15 do not.
    function automatic logic sets_flags(input logic [3:0] ctrl);
        return (ctrl >= SETC) && (ctrl <= SHR) && (ctrl != MOV);
    endfunction

endpackage

// File: rtl/ccr_reg.sv
// Condition-code register. With EX_MEM_CCR_SAVE_EN defined it also holds a
// shadow copy that can be saved to / restored from (or swapped) each cycle.
module ccr_reg
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic update,
    input  ccr_t flags_in,
`ifdef EX_MEM_CCR_SAVE_EN
    input  logic save,
    input  logic restore,
`endif
    output ccr_t ccr
);

`ifdef EX_MEM_CCR_SAVE_EN
    ccr_t shadow;

    // Restore wins over an ALU update; save+restore together swaps the two copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr    <= '0;
            shadow <= '0;
        end else begin
            if (restore)
                ccr <= shadow;
            else if (update)
                ccr <= flags_in;
            if (save)
                shadow <= ccr;
        end
    end
`else
    // Flags change only when a committed instruction produces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ccr <= '0;
        else if (update)
            ccr <= flags_in;
    end
`endif

endmodule

// File: rtl/ex_mem_pipe.sv
// Two-stage EX->MEM pipeline register with stall/flush and a condition-code
// register. Optional feature macro: EX_MEM_CCR_SAVE_EN (adds ccr_save /
// ccr_restore inputs and a shadow CCR).
module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_out,
    input  logic         carry_in,
    input  logic         zero_in,
    input  logic         neg_in,
    input  logic [2:0]   dst_reg,
    input  logic         wb_in,
    input  logic         mem_read_in,
    input  logic         mem_write_in,
`ifdef EX_MEM_CCR_SAVE_EN
    input  logic         ccr_save,
    input  logic         ccr_restore,
`endif
    output logic [N-1:0] result_prev1,
    output logic [2:0]   reg2_buf2,
    output logic         wb1,
    output logic         mem_write1,
    output logic         mem_read1,
    output logic [N-1:0] result_prev2,
    output logic [2:0]   reg2_buf3,
    output logic         wb2,
    output logic         mem_write2,
    output logic         mem_read_load_case,
    output logic         carry_flag,
    output logic         zero_flag,
    output logic         neg_flag
);

    logic commit;
    logic ccr_update;
    ccr_t flags_in;
    ccr_t ccr;

    assign commit     = in_valid && !stall && !flush;
    assign ccr_update = commit && sets_flags(alu_ctrl);
    assign flags_in   = '{carry: carry_in, zero: zero_in, neg: neg_in};

    // Flush bubbles stage 1 even under stall while stage 2 still drains it;
    // a plain stall freezes both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_prev1       <= '0;
            reg2_buf2          <= '0;
            wb1                <= 1'b0;
            mem_write1         <= 1'b0;
            mem_read1          <= 1'b0;
            result_prev2       <= '0;
            reg2_buf3          <= '0;
            wb2                <= 1'b0;
            mem_write2         <= 1'b0;
            mem_read_load_case <= 1'b0;
        end else if (flush || !stall) begin
            result_prev2       <= result_prev1;
            reg2_buf3          <= reg2_buf2;
            wb2                <= wb1;
            mem_write2         <= mem_write1;
            mem_read_load_case <= mem_read1;
            if (flush) begin
                result_prev1 <= '0;
                reg2_buf2    <= '0;
                wb1          <= 1'b0;
                mem_write1   <= 1'b0;
                mem_read1    <= 1'b0;
            end else begin
                result_prev1 <= alu_out;
                reg2_buf2    <= dst_reg;
                wb1          <= wb_in && in_valid;
                mem_write1   <= mem_write_in && in_valid;
                mem_read1    <= mem_read_in && in_valid;
            end
        end
    end

    ccr_reg u_ccr (
        .clk      (clk),
        .rst_n    (rst_n),
        .update   (ccr_update),
        .flags_in (flags_in),
`ifdef EX_MEM_CCR_SAVE_EN
        .save     (ccr_save),
        .restore  (ccr_restore),
`endif
        .ccr      (ccr)
    );

    assign carry_flag = ccr.carry;
    assign zero_flag  = ccr.zero;
    assign neg_flag   = ccr.neg;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: stimulus pushes hand-computed expected
// output snapshots tagged with the cycle they apply to; a monitor pops and
// compares them on the falling edge. Reset-time expectations go to a second
// queue checked just after rst_n falls.
module tb_ex_mem_pipe;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         stall, flush, in_valid;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_out;
    logic         carry_in, zero_in, neg_in;
    logic [2:0]   dst_reg;
    logic         wb_in, mem_read_in, mem_write_in;
    logic         ccr_save, ccr_restore;
    logic [N-1:0] result_prev1, result_prev2;
    logic [2:0]   reg2_buf2, reg2_buf3;
    logic         wb1, mem_write1, mem_read1;
    logic         wb2, mem_write2, mem_read_load_case;
    logic         carry_flag, zero_flag, neg_flag;

    ex_mem_pipe #(.N(N)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .flush              (flush),
        .in_valid           (in_valid),
        .alu_ctrl           (alu_ctrl),
        .alu_out            (alu_out),
        .carry_in           (carry_in),
        .zero_in            (zero_in),
        .neg_in             (neg_in),
        .dst_reg            (dst_reg),
        .wb_in              (wb_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
`ifdef EX_MEM_CCR_SAVE_EN
        .ccr_save           (ccr_save),
        .ccr_restore        (ccr_restore),
`endif
        .result_prev1       (result_prev1),
        .reg2_buf2          (reg2_buf2),
        .wb1                (wb1),
        .mem_write1         (mem_write1),
        .mem_read1          (mem_read1),
        .result_prev2       (result_prev2),
        .reg2_buf3          (reg2_buf3),
        .wb2                (wb2),
        .mem_write2         (mem_write2),
        .mem_read_load_case (mem_read_load_case),
        .carry_flag         (carry_flag),
        .zero_flag          (zero_flag),
        .neg_flag           (neg_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        string        name;
        logic [N-1:0] r1;
        logic [2:0]   b2;
        logic [2:0]   c1;   // {wb1, mem_write1, mem_read1}
        logic [N-1:0] r2;
        logic [2:0]   b3;
        logic [2:0]   c2;   // {wb2, mem_write2, mem_read_load_case}
        logic [2:0]   ccr;  // {C, Z, N}
        bit           ccr_only;
    } exp_t;

    exp_t q[$];
    exp_t rq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        logic [2*N+17:0] act, req;
        act = {result_prev1, reg2_buf2, wb1, mem_write1, mem_read1,
               result_prev2, reg2_buf3, wb2, mem_write2, mem_read_load_case,
               carry_flag, zero_flag, neg_flag};
        req = {e.r1, e.b2, e.c1, e.r2, e.b3, e.c2, e.ccr};
        if (e.ccr_only) begin
            act = {{(2*N+15){1'b0}}, act[2:0]};
            req = {{(2*N+15){1'b0}}, req[2:0]};
        end
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (r1|b2|c1|r2|b3|c2|czn)", e.name, act, req);
        end
    endtask

    // Clocked monitor: compare every snapshot due for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) check(q.pop_front());
    end

    // Reset monitor: outputs must already be cleared shortly after rst_n falls.
    always @(negedge rst_n) begin
        #1;
        while (rq.size() > 0) check(rq.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ctrl, input logic [N-1:0] alu,
                         input logic [2:0] czn, input logic [2:0] dst, input logic [2:0] ctl,
                         input logic st, input logic fl);
        in_valid = v;  alu_ctrl = ctrl;  alu_out = alu;
        {carry_in, zero_in, neg_in} = czn;
        dst_reg = dst;
        {wb_in, mem_write_in, mem_read_in} = ctl;
        stall = st;  flush = fl;
    endtask

    task automatic exp_state(input string nm, input int ahead,
                             input logic [N-1:0] r1, input logic [2:0] b2, input logic [2:0] c1,
                             input logic [N-1:0] r2, input logic [2:0] b3, input logic [2:0] c2,
                             input logic [2:0] ccr);
        exp_t e;
        e = '{cyc: cyc + ahead, name: nm, r1: r1, b2: b2, c1: c1,
              r2: r2, b3: b3, c2: c2, ccr: ccr, ccr_only: 1'b0};
        q.push_back(e);
    endtask

    task automatic exp_ccr(input string nm, input logic [2:0] ccr);
        exp_t e;
        e = '{cyc: cyc + 1, name: nm, r1: '0, b2: '0, c1: '0,
              r2: '0, b3: '0, c2: '0, ccr: ccr, ccr_only: 1'b1};
        q.push_back(e);
    endtask

    // One pipeline step: apply inputs, predict state after the next edge, clock.
    task automatic step(input string nm,
                        input logic v, input logic [3:0] ctrl, input logic [N-1:0] alu,
                        input logic [2:0] czn, input logic [2:0] dst, input logic [2:0] ctl,
                        input logic st, input logic fl,
                        input logic [N-1:0] r1, input logic [2:0] b2, input logic [2:0] c1,
                        input logic [N-1:0] r2, input logic [2:0] b3, input logic [2:0] c2,
                        input logic [2:0] ccr);
        drive(v, ctrl, alu, czn, dst, ctl, st, fl);
        exp_state(nm, 1, r1, b2, c1, r2, b3, c2, ccr);
        tick();
    endtask

    initial begin
        ccr_save = 1'b0;
        ccr_restore = 1'b0;
        drive(0, 4'd0, '0, 3'b000, 3'd0, 3'b000, 0, 0);
        rst_n = 1'b0;
        tick();
        exp_state("reset_state", 0, '0, 3'd0, 3'b000, '0, 3'd0, 3'b000, 3'b000);
        rst_n = 1'b1;

        //    name        v  ctrl   alu        czn     dst  ctl     st fl | r1        b2   c1      r2        b3   c2      ccr
        step("add_zero",  1, 4'd5,  16'h0000, 3'b110, 3'd3, 3'b100, 0, 0, 16'h0000, 3'd3, 3'b100, 16'h0000, 3'd0, 3'b000, 3'b110);
        step("sub_s2",    1, 4'd6,  16'h1234, 3'b101, 3'd5, 3'b101, 0, 0, 16'h1234, 3'd5, 3'b101, 16'h0000, 3'd3, 3'b100, 3'b101);
        step("std_keep",  1, 4'd13, 16'hBEEF, 3'b010, 3'd2, 3'b010, 0, 0, 16'hBEEF, 3'd2, 3'b010, 16'h1234, 3'd5, 3'b101, 3'b101);
        step("mov_keep",  1, 4'd4,  16'h00FF, 3'b010, 3'd7, 3'b100, 0, 0, 16'h00FF, 3'd7, 3'b100, 16'hBEEF, 3'd2, 3'b010, 3'b101);
        step("bubble",    0, 4'd5,  16'hAAAA, 3'b010, 3'd6, 3'b111, 0, 0, 16'hAAAA, 3'd6, 3'b000, 16'h00FF, 3'd7, 3'b100, 3'b101);
        step("nop_keep",  1, 4'd0,  16'h5555, 3'b111, 3'd1, 3'b000, 0, 0, 16'h5555, 3'd1, 3'b000, 16'hAAAA, 3'd6, 3'b000, 3'b101);
        step("ctrl12",    1, 4'd12, 16'h0F0F, 3'b010, 3'd4, 3'b100, 0, 0, 16'h0F0F, 3'd4, 3'b100, 16'h5555, 3'd1, 3'b000, 3'b010);
        step("ctrl1",     1, 4'd1,  16'h0001, 3'b101, 3'd2, 3'b101, 0, 0, 16'h0001, 3'd2, 3'b101, 16'h0F0F, 3'd4, 3'b100, 3'b101);
        step("stall_a",   1, 4'd5,  16'h9999, 3'b010, 3'd1, 3'b111, 1, 0, 16'h0001, 3'd2, 3'b101, 16'h0F0F, 3'd4, 3'b100, 3'b101);
        step("stall_b",   1, 4'd2,  16'h8888, 3'b000, 3'd6, 3'b101, 1, 0, 16'h0001, 3'd2, 3'b101, 16'h0F0F, 3'd4, 3'b100, 3'b101);
        step("stall_c",   0, 4'd9,  16'h7777, 3'b111, 3'd0, 3'b011, 1, 0, 16'h0001, 3'd2, 3'b101, 16'h0F0F, 3'd4, 3'b100, 3'b101);
        step("flush_stl", 1, 4'd5,  16'h7777, 3'b010, 3'd3, 3'b100, 1, 1, 16'h0000, 3'd0, 3'b000, 16'h0001, 3'd2, 3'b101, 3'b101);
        step("flush",     1, 4'd6,  16'h3333, 3'b010, 3'd5, 3'b111, 0, 1, 16'h0000, 3'd0, 3'b000, 16'h0000, 3'd0, 3'b000, 3'b101);
        step("ldm_keep",  1, 4'd14, 16'hCAFE, 3'b010, 3'd5, 3'b100, 0, 0, 16'hCAFE, 3'd5, 3'b100, 16'h0000, 3'd0, 3'b000, 3'b101);
        step("c15_keep",  1, 4'd15, 16'h1111, 3'b010, 3'd1, 3'b100, 0, 0, 16'h1111, 3'd1, 3'b100, 16'hCAFE, 3'd5, 3'b100, 3'b101);
        step("ctrl3",     1, 4'd3,  16'h2222, 3'b000, 3'd6, 3'b110, 0, 0, 16'h2222, 3'd6, 3'b110, 16'h1111, 3'd1, 3'b100, 3'b000);

        // Asynchronous reset between clock edges, with wb1=wb2=1 in flight.
        @(negedge clk);
        #1;
        rq.push_back('{cyc: cyc, name: "async_rst", r1: '0, b2: '0, c1: '0,
                       r2: '0, b3: '0, c2: '0, ccr: '0, ccr_only: 1'b0});
        rst_n = 1'b0;
        exp_state("rst_held", 1, '0, 3'd0, 3'b000, '0, 3'd0, 3'b000, 3'b000);
        tick();
        rst_n = 1'b1;

        step("resume",    1, 4'd5,  16'h0042, 3'b100, 3'd2, 3'b100, 0, 0, 16'h0042, 3'd2, 3'b100, 16'h0000, 3'd0, 3'b000, 3'b100);
        step("idle",      0, 4'd0,  16'h0000, 3'b000, 3'd0, 3'b000, 0, 0, 16'h0000, 3'd0, 3'b000, 16'h0042, 3'd2, 3'b100, 3'b100);

`ifdef EX_MEM_CCR_SAVE_EN
        drive(1, 4'd1, '0, 3'b101, 3'd0, 3'b000, 0, 0); exp_ccr("ccr_set101", 3'b101); tick();
        drive(0, 4'd0, '0, 3'b000, 3'd0, 3'b000, 0, 0); ccr_save = 1'b1;
        exp_ccr("ccr_save", 3'b101); tick();
        ccr_save = 1'b0;
        drive(1, 4'd5, '0, 3'b010, 3'd0, 3'b000, 0, 0); exp_ccr("ccr_alu010", 3'b010); tick();
        drive(1, 4'd5, '0, 3'b111, 3'd0, 3'b000, 0, 0); ccr_restore = 1'b1;
        exp_ccr("ccr_restore", 3'b101); tick();
        ccr_restore = 1'b0;
        drive(1, 4'd5, '0, 3'b000, 3'd0, 3'b000, 0, 0); exp_ccr("ccr_alu000", 3'b000); tick();
        drive(0, 4'd0, '0, 3'b000, 3'd0, 3'b000, 1, 0); ccr_save = 1'b1; ccr_restore = 1'b1;
        exp_ccr("ccr_swap", 3'b101); tick();
        ccr_save = 1'b0;
        drive(0, 4'd0, '0, 3'b000, 3'd0, 3'b000, 0, 0);
        exp_ccr("ccr_swap_back", 3'b000); tick();
        ccr_restore = 1'b0;
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && (q.size() > 0 || rq.size() > 0); i++) tick();
        if (q.size() > 0 || rq.size() > 0) begin
            $display("FAIL drain: got %0d unchecked entries expected 0", q.size() + rq.size());
            tests += q.size() + rq.size();
            fails += q.size() + rq.size();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
